// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, types and helpers for the note synthesiser.
//   NUM_STRINGS / NUM_FRETS : note-word geometry (6 strings, frets 0..4).
//   calc_half()             : square-wave half-period in clk cycles for a
//                             string/fret, CLK_HZ/(2*f) rounded. Evaluated
//                             only at elaboration to build the HALF table.
//   fret_decode()           : highest set fret bit of one string in a note word.
package synth_pkg;

    localparam int unsigned NUM_STRINGS = 6;
    localparam int unsigned NUM_FRETS   = 5;
    localparam int unsigned HALF_W      = 19;

    // Anchor half-periods below are quoted at this reference clock.
    localparam longint unsigned REF_CLK_HZ = 64'd50_000_000;

    typedef struct packed {
        logic       valid;
        logic [2:0] fret;
    } fret_sel_t;

    // Open-string half-periods at REF_CLK_HZ: E2 A2 D3 G3 B3 E4.
    function automatic int unsigned open_half(input int unsigned s);
        case (s)
            0:       return 303355;
            1:       return 227273;
            2:       return 170262;
            3:       return 127551;
            4:       return 101239;
            default: return 75843;
        endcase
    endfunction

    // Each fret raises the pitch a semitone, shrinking the period by 2^(1/12).
    function automatic logic [HALF_W-1:0] calc_half(input longint unsigned clk_hz,
                                                    input int unsigned     s,
                                                    input int unsigned     f);
        real h;
        h = real'(open_half(s)) * (real'(clk_hz) / real'(REF_CLK_HZ))
            / (2.0 ** (real'(f) / 12.0));
        return HALF_W'($rtoi(h + 0.5));
    endfunction

    // Bits 31:30 are never addressed (max index is 6*4+5 = 29).
    function automatic fret_sel_t fret_decode(input logic [31:0]  note,
                                              input int unsigned  s);
        fret_sel_t  r;
        logic [4:0] idx;
        r = '0;
        for (int unsigned f = 0; f < NUM_FRETS; f++) begin
            idx = 5'(6 * f + s);
            if (note[idx]) begin
                r.valid = 1'b1;
                r.fret  = 3'(f);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/square_voice.sv
// square_voice: one string oscillator.
//   clk, reset    : system clock, synchronous active-high reset
//   restart       : clears counter and phase (beat strobe)
//   half_period   : cycles per half wave
//   on            : voice audible; otherwise contributes 0
//   contribution  : +AMP in phase 0, -AMP in phase 1 (signed)
module square_voice #(
    parameter logic signed [31:0] AMP = 32'sh0400_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        restart,
    input  logic [18:0] half_period,
    input  logic        on,
    output logic [31:0] contribution
);

    logic [18:0] cnt_q, cnt_d;
    logic        phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 19'd1;
        phase_d = phase_q;
        if (restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == half_period - 19'd1) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign contribution = on ? (phase_q ? -AMP : AMP) : '0;

endmodule

// File: rtl/note_synth.sv
// note_synth: latches a note word on each beat, plays up to six square-wave
// string voices, and streams their sum to the audio codec FIFO.
//   clk, reset               : system clock, synchronous active-high reset
//   beat                     : one-cycle strobe, latches note and restarts voices
//   play_en                  : 0 mutes (samples still emitted, value 0)
//   note                     : bit 6f+s = string s at fret f
//   audio_out_allowed        : codec FIFO has room
//   write_audio_out          : one-cycle write strobe
//   left/right_channel_audio_out : signed sample (identical)
//   active_voices            : bit s = string s sounding
//   underrun                 : sticky, a sample was overwritten before being sent
module note_synth
    import synth_pkg::*;
#(
    parameter int unsigned        CLK_HZ     = 50000000,
    parameter int unsigned        SAMPLE_DIV = 1042,
    parameter logic signed [31:0] AMP        = 32'sh0400_0000,
    parameter int unsigned        SUSTAIN    = 40000000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   beat,
    input  logic                   play_en,
    input  logic [31:0]            note,
    input  logic                   audio_out_allowed,
    output logic                   write_audio_out,
    output logic [31:0]            left_channel_audio_out,
    output logic [31:0]            right_channel_audio_out,
    output logic [NUM_STRINGS-1:0] active_voices,
    output logic                   underrun
);

    logic [31:0] note_q, note_d;
    logic [31:0] sustain_q, sustain_d;
    logic [31:0] div_q, div_d;
    logic [31:0] sample_q, sample_d;
    logic        pending_q, pending_d;
    logic        underrun_q, underrun_d;

    logic                   sounding;
    logic                   tick;
    logic                   write;
    logic signed [31:0]     mix;
    logic [NUM_STRINGS-1:0] voice_on;
    logic [31:0]            contrib [NUM_STRINGS];
    logic [HALF_W-1:0]      half_tab [NUM_STRINGS][NUM_FRETS];

    assign sounding = (sustain_q != '0) && play_en;

    for (genvar gs = 0; gs < NUM_STRINGS; gs++) begin : g_string
        for (genvar gf = 0; gf < NUM_FRETS; gf++) begin : g_fret
            localparam logic [HALF_W-1:0] H = calc_half(CLK_HZ, gs, gf);
            assign half_tab[gs][gf] = H;
        end

        fret_sel_t sel;
        assign sel          = fret_decode(note_q, gs);
        assign voice_on[gs] = sel.valid && sounding;

        square_voice #(.AMP(AMP)) u_voice (
            .clk          (clk),
            .reset        (reset),
            .restart      (beat),
            .half_period  (half_tab[gs][sel.fret]),
            .on           (voice_on[gs]),
            .contribution (contrib[gs])
        );
    end

    // Six voices at most 6*AMP in magnitude, which fits without saturation.
    always_comb begin
        mix = '0;
        for (int unsigned i = 0; i < NUM_STRINGS; i++) begin
            mix = mix + $signed(contrib[i]);
        end
    end

    assign tick  = (div_q == SAMPLE_DIV - 1);
    assign write = pending_q && audio_out_allowed;

    // On a tick the mix is taken from current voice state, so a beat in the
    // same cycle only affects later samples. A write in the tick cycle sends
    // the old sample while the new one becomes pending.
    always_comb begin
        note_d     = beat ? note : note_q;
        sustain_d  = beat ? SUSTAIN : ((sustain_q != '0) ? sustain_q - 32'd1 : '0);
        div_d      = tick ? '0 : div_q + 32'd1;
        sample_d   = tick ? mix : sample_q;
        pending_d  = tick ? 1'b1 : (write ? 1'b0 : pending_q);
        underrun_d = underrun_q || (tick && pending_q && !write);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            note_q     <= '0;
            sustain_q  <= '0;
            div_q      <= '0;
            sample_q   <= '0;
            pending_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            note_q     <= note_d;
            sustain_q  <= sustain_d;
            div_q      <= div_d;
            sample_q   <= sample_d;
            pending_q  <= pending_d;
            underrun_q <= underrun_d;
        end
    end

    assign write_audio_out         = write;
    assign left_channel_audio_out  = sample_q;
    assign right_channel_audio_out = sample_q;
    assign active_voices           = voice_on;
    assign underrun                = underrun_q;

endmodule

// File: tb/tb_note_synth.sv
// tb_note_synth: randomized and directed stimulus for note_synth, compared
// every cycle against a behavioural model that derives voice phase from the
// number of cycles since the last beat.
module tb_note_synth;

    localparam int unsigned T_CLK_HZ = 100000;
    localparam int unsigned T_DIV    = 40;
    localparam int unsigned T_SUS    = 3000;
    localparam int          AMP_I    = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        reset, beat, play_en, allowed;
    logic [31:0] note;
    logic        write_audio_out;
    logic [31:0] left_out, right_out;
    logic [5:0]  active_voices;
    logic        underrun;

    always #5 clk = ~clk;

    note_synth #(
        .CLK_HZ     (T_CLK_HZ),
        .SAMPLE_DIV (T_DIV),
        .AMP        (32'sh0400_0000),
        .SUSTAIN    (T_SUS)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .beat                    (beat),
        .play_en                 (play_en),
        .note                    (note),
        .audio_out_allowed       (allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_out),
        .right_channel_audio_out (right_out),
        .active_voices           (active_voices),
        .underrun                (underrun)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    // ---- behavioural model ----
    int unsigned m_cyc   = 0;        // edges since reset release
    logic [31:0] m_note  = '0;
    longint      m_age   = T_SUS;    // edges since last beat, saturating
    bit          m_pend  = 1'b0;
    bit          m_under = 1'b0;
    logic [31:0] m_held  = '0;

    function automatic int anchor(input int s);
        int a [6] = '{303355, 227273, 170262, 127551, 101239, 75843};
        return a[s];
    endfunction

    function automatic int exp_half(input int s, input int f);
        real r;
        r = real'(anchor(s)) * real'(T_CLK_HZ) / 50.0e6 * (2.0 ** (-real'(f) / 12.0));
        return $rtoi(r + 0.5);
    endfunction

    function automatic int model_fret(input logic [31:0] n, input int s);
        for (int f = 4; f >= 0; f--) begin
            if (((n >> (6 * f + s)) & 32'd1) != 32'd0) return f;
        end
        return -1;
    endfunction

    function automatic bit model_on(input int s, input bit pe);
        return (model_fret(m_note, s) >= 0) && (m_age < T_SUS) && pe;
    endfunction

    function automatic logic [31:0] model_mix(input bit pe);
        int sum = 0;
        for (int s = 0; s < 6; s++) begin
            if (model_on(s, pe)) begin
                if (((m_age / exp_half(s, model_fret(m_note, s))) % 2) == 1) sum -= AMP_I;
                else sum += AMP_I;
            end
        end
        return 32'(sum);
    endfunction

    task automatic run_cycle(input bit b, input logic [31:0] n, input bit pe,
                             input bit al, input bit rst, input bit do_chk);
        logic [5:0]  exp_act;
        logic [31:0] mix;
        bit          exp_wr, tick;
        reset   = rst;
        beat    = b;
        note    = n;
        play_en = pe;
        allowed = al;
        #1;
        exp_wr = m_pend && al;
        for (int s = 0; s < 6; s++) exp_act[s] = model_on(s, pe);
        if (do_chk) begin
            check_eq("write", 64'(write_audio_out), 64'(exp_wr));
            check_eq("active", 64'(active_voices), 64'(exp_act));
            check_eq("underrun", 64'(underrun), 64'(m_under));
            check_eq("left", 64'(left_out), 64'(m_held));
            check_eq("right", 64'(right_out), 64'(m_held));
        end
        mix = model_mix(pe);
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_note = '0; m_age = T_SUS;
            m_pend = 1'b0; m_under = 1'b0; m_held = '0;
        end else begin
            tick = ((m_cyc + 1) % T_DIV) == 0;
            if (tick) begin
                if (m_pend && !exp_wr) m_under = 1'b1;
                m_held = mix;
                m_pend = 1'b1;
            end else if (exp_wr) begin
                m_pend = 1'b0;
            end
            m_cyc++;
            if (b) begin
                m_note = n;
                m_age  = 0;
            end else if (m_age < T_SUS) begin
                m_age++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_idle(input int cycles, input logic [31:0] n, input bit pe, input bit al);
        for (int i = 0; i < cycles; i++) run_cycle(1'b0, n, pe, al, 1'b0, 1'b1);
    endtask

    initial begin
        logic [31:0] rn;
        bit          rpe;
        @(negedge clk);
        // Unchecked edges establish a defined state, then reset is checked.
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) run_cycle(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);

        // Low E open: phase flips after the E2 half-period.
        run_idle(10, 32'h1, 1'b1, 1'b1);
        run_cycle(1'b1, 32'h1, 1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(1400, 32'h1, 1'b1, 1'b1);

        // String 0 open plus fret 4: highest fret wins.
        run_cycle(1'b1, 32'h0100_0001, 1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(800, 32'h0100_0001, 1'b1, 1'b1);

        // All open, beat coincident with a sample tick, then sustain expiry.
        while (((m_cyc + 1) % T_DIV) != 0) run_cycle(1'b0, 32'h3F, 1'b1, 1'b1, 1'b0, 1'b1);
        run_cycle(1'b1, 32'h3F, 1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(T_SUS + 200, 32'h3F, 1'b1, 1'b1);

        // FIFO blocked across three ticks, then released.
        run_cycle(1'b1, 32'h3F, 1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(3 * T_DIV + 5, 32'h3F, 1'b1, 1'b0);
        run_idle(60, 32'h3F, 1'b1, 1'b1);

        // Muted: zero samples keep flowing.
        run_cycle(1'b1, 32'h3F, 1'b0, 1'b1, 1'b0, 1'b1);
        run_idle(200, 32'h3F, 1'b0, 1'b1);

        // Reset mid-note.
        run_cycle(1'b1, 32'h3F, 1'b1, 1'b1, 1'b0, 1'b1);
        run_idle(100, 32'h3F, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h3F, 1'b1, 1'b1, 1'b1, 1'b1);
        run_idle(100, 32'h3F, 1'b1, 1'b1);

        // Randomized traffic.
        rn  = $urandom();
        rpe = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            bit rb;
            rb = ($urandom_range(0, 299) == 0);
            if (rb) rn = ($urandom_range(0, 1) == 0) ? $urandom() : (32'h1 << $urandom_range(0, 29));
            if ($urandom_range(0, 399) == 0) rpe = ~rpe;
            run_cycle(rb, rn, rpe, $urandom_range(0, 9) != 0,
                      $urandom_range(0, 2999) == 0, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
